sram_mem_ctrl: RTL and testbench

SRAM_MEM_CTRL -- requirements
Module: sram_mem_ctrl

---
 rtl/sram_mem_ctrl.sv | 131 +++++++++++++
 tb/tb_sram_mem_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/sram_mem_ctrl.sv
// rtl/sram_mem_ctrl.sv - single-port 32-bit SRAM controller with zero-fill after reset,
// byte-masked writes and optional per-byte even parity.
module sram_mem_ctrl #(
  parameter int MEM_AWIDTH  = 17,
  parameter bit INIT_ENABLE = 1'b1,
  parameter bit PARITY_EN   = 1'b1
) (
  input  logic                  HCLK,
  input  logic                  aresetn,
  input  logic                  mem_write,
  input  logic                  mem_read,
  input  logic [MEM_AWIDTH-1:0] mem_addr,
  input  logic [3:0]            mem_byteen,
  input  logic [31:0]           mem_wdata,
  output logic [31:0]           mem_rdata,
  output logic                  BUSY,
  output logic                  init_done,
  output logic                  parity_err,
  output logic                  wr_collision
);

  localparam int DEPTH = 1 << MEM_AWIDTH;
  localparam logic [MEM_AWIDTH:0] LAST_WORD = {1'b0, {MEM_AWIDTH{1'b1}}};

  typedef enum logic [1:0] {RST_WAIT, INIT, READY} state_t;

  state_t                state;
  logic [MEM_AWIDTH:0]   init_cnt;
  logic [31:0]           mem [DEPTH];
  logic [3:0]            wr_be;
  logic [MEM_AWIDTH-1:0] wr_addr;
  logic [31:0]           wr_data;
  logic [31:0]           rd_word;
  logic                  perr_now;

  assign rd_word = mem[mem_addr];

  // One shared write port: the fill owns it in INIT; a simultaneous read drops the user write.
  always_comb begin
    wr_be   = 4'b0000;
    wr_addr = mem_addr;
    wr_data = mem_wdata;
    if (state == INIT) begin
      wr_be   = 4'b1111;
      wr_addr = init_cnt[MEM_AWIDTH-1:0];
      wr_data = 32'h0;
    end else if (state == READY && mem_write && !mem_read) begin
      wr_be = mem_byteen;
    end
  end

  always_ff @(posedge HCLK) begin
    for (int n = 0; n < 4; n++) begin
      if (wr_be[n]) mem[wr_addr][8*n +: 8] <= wr_data[8*n +: 8];
    end
  end

  generate
    if (PARITY_EN) begin : g_par
      logic [3:0] par_mem [DEPTH];
      logic [3:0] wr_par;
      logic [3:0] rd_par;

      always_comb begin
        wr_par = 4'b0000;
        rd_par = 4'b0000;
        for (int n = 0; n < 4; n++) begin
          wr_par[n] = ^wr_data[8*n +: 8];
          rd_par[n] = ^rd_word[8*n +: 8];
        end
      end

      always_ff @(posedge HCLK) begin
        for (int n = 0; n < 4; n++) begin
          if (wr_be[n]) par_mem[wr_addr][n] <= wr_par[n];
        end
      end

      assign perr_now = |(rd_par ^ par_mem[mem_addr]);
    end else begin : g_nopar
      assign perr_now = 1'b0;
    end
  endgenerate

  always_ff @(posedge HCLK or negedge aresetn) begin
    if (!aresetn) begin
      state        <= RST_WAIT;
      init_cnt     <= '0;
      BUSY         <= 1'b1;
      init_done    <= 1'b0;
      mem_rdata    <= 32'h0;
      parity_err   <= 1'b0;
      wr_collision <= 1'b0;
    end else begin
      parity_err <= 1'b0;
      case (state)
        RST_WAIT: begin
          init_cnt <= '0;
          if (INIT_ENABLE) begin
            state <= INIT;
          end else begin
            state     <= READY;
            BUSY      <= 1'b0;
            init_done <= 1'b1;
          end
        end
        INIT: begin
          init_cnt <= init_cnt + 1'b1;
          if (init_cnt == LAST_WORD) begin
            state     <= READY;
            BUSY      <= 1'b0;
            init_done <= 1'b1;
          end
        end
        READY: begin
          if (mem_read) begin
            mem_rdata  <= rd_word;
            parity_err <= perr_now;
            if (mem_write && |mem_byteen) wr_collision <= 1'b1;
          end
        end
        default: begin
          state     <= RST_WAIT;
          BUSY      <= 1'b1;
          init_done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_mem_ctrl.sv
// tb/tb_sram_mem_ctrl.sv - self-checking bench for sram_mem_ctrl at MEM_AWIDTH=4
// against a cycle-count-based behavioural model plus literal expectations.
module tb_sram_mem_ctrl;

  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic          HCLK = 1'b0;
  logic          aresetn = 1'b0;
  logic          mem_write = 1'b0;
  logic          mem_read = 1'b0;
  logic [AW-1:0] mem_addr = '0;
  logic [3:0]    mem_byteen = 4'h0;
  logic [31:0]   mem_wdata = 32'h0;
  logic [31:0]   mem_rdata;
  logic          BUSY;
  logic          init_done;
  logic          parity_err;
  logic          wr_collision;

  sram_mem_ctrl #(.MEM_AWIDTH(AW), .INIT_ENABLE(1'b1), .PARITY_EN(1'b1)) dut (
    .HCLK(HCLK), .aresetn(aresetn), .mem_write(mem_write), .mem_read(mem_read),
    .mem_addr(mem_addr), .mem_byteen(mem_byteen), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .BUSY(BUSY), .init_done(init_done),
    .parity_err(parity_err), .wr_collision(wr_collision)
  );

  always #5 HCLK = ~HCLK;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: the array is busy for 1 + DEPTH edges after release; edge k (2..17) clears word k-2.
  logic [31:0] m_mem [DEPTH];
  logic [3:0]  m_par [DEPTH];
  int          since_rel = 0;
  logic [31:0] e_rdata = 32'h0;
  logic        e_perr = 1'b0;
  logic        e_col = 1'b0;

  function automatic logic [3:0] par4(input logic [31:0] w);
    return {^w[31:24], ^w[23:16], ^w[15:8], ^w[7:0]};
  endfunction

  always @(posedge HCLK or negedge aresetn) begin
    if (!aresetn) begin
      since_rel = 0;
      e_rdata   = 32'h0;
      e_perr    = 1'b0;
      e_col     = 1'b0;
    end else begin
      e_perr = 1'b0;
      if (since_rel >= 1 && since_rel <= DEPTH) begin
        m_mem[since_rel-1] = 32'h0;
        m_par[since_rel-1] = 4'h0;
      end else if (since_rel > DEPTH) begin
        if (mem_read) begin
          e_rdata = m_mem[mem_addr];
          e_perr  = (m_par[mem_addr] != par4(m_mem[mem_addr]));
          if (mem_write && mem_byteen != 4'h0) e_col = 1'b1;
        end else if (mem_write) begin
          for (int n = 0; n < 4; n++) begin
            if (mem_byteen[n]) begin
              m_mem[mem_addr][8*n +: 8] = mem_wdata[8*n +: 8];
              m_par[mem_addr][n]        = ^mem_wdata[8*n +: 8];
            end
          end
        end
      end
      if (since_rel < 100000) since_rel++;
    end
  end

  always @(negedge HCLK) begin
    check("busy", {31'b0, BUSY}, {31'b0, since_rel <= DEPTH});
    check("init_done", {31'b0, init_done}, {31'b0, since_rel > DEPTH});
    check("rdata", mem_rdata, e_rdata);
    check("parity_err", {31'b0, parity_err}, {31'b0, e_perr});
    check("wr_collision", {31'b0, wr_collision}, {31'b0, e_col});
  end

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic idle();
    mem_write = 1'b0;
    mem_read  = 1'b0;
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [3:0] be, input logic [31:0] d);
    mem_write = 1'b1; mem_read = 1'b0; mem_addr = a; mem_byteen = be; mem_wdata = d;
    tick();
    idle();
  endtask

  task automatic do_read(input logic [AW-1:0] a);
    mem_write = 1'b0; mem_read = 1'b1; mem_addr = a;
    tick();
    idle();
  endtask

  // Returns the number of cycles BUSY stays high after release, including the release cycle.
  task automatic measure_busy(output int cyc);
    cyc = 1;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (BUSY) cyc++;
      else begin
        idle();
        break;
      end
    end
  endtask

  int busy_cyc;

  initial begin
    tick(); tick();
    check("reset_busy", {31'b0, BUSY}, 32'd1);
    check("reset_init_done", {31'b0, init_done}, 32'd0);
    check("reset_rdata", mem_rdata, 32'h0);
    check("reset_collision", {31'b0, wr_collision}, 32'd0);

    aresetn = 1'b1;
    measure_busy(busy_cyc);
    check("busy_cycles", busy_cyc, 32'd17);
    check("init_done_after_fill", {31'b0, init_done}, 32'd1);

    for (int i = 0; i < DEPTH; i++) begin
      do_read(AW'(i));
      check("fill_zero", mem_rdata, 32'h0);
    end

    do_write(4'd3, 4'hF, 32'hDEADBEEF);
    do_write(4'd3, 4'h1, 32'h00000011);
    do_read(4'd3);
    check("byte_merge", mem_rdata, 32'hDEADBE11);

    do_write(4'd3, 4'h0, 32'hFFFFFFFF);
    do_read(4'd3);
    check("byteen_zero", mem_rdata, 32'hDEADBE11);
    check("byteen_zero_nocol", {31'b0, wr_collision}, 32'd0);

    do_write(4'd15, 4'b1010, 32'h12345678);
    do_write(4'd0, 4'b0110, 32'hCAFEF00D);
    do_read(4'd15);
    check("mask_1010", mem_rdata, 32'h12005600);
    do_read(4'd0);
    check("mask_0110", mem_rdata, 32'h00FEF000);
    tick(); tick();
    check("rdata_hold", mem_rdata, 32'h00FEF000);

    mem_write = 1'b1; mem_read = 1'b1; mem_addr = 4'd5; mem_byteen = 4'hF; mem_wdata = 32'hA5A5A5A5;
    tick();
    idle();
    check("collision_rdata", mem_rdata, 32'h0);
    check("collision_flag", {31'b0, wr_collision}, 32'd1);
    do_read(4'd5);
    check("collision_dropped", mem_rdata, 32'h0);

    do_write(4'd2, 4'hF, 32'h0F0F0301);
    dut.g_par.par_mem[2][1] = ~dut.g_par.par_mem[2][1];
    m_par[2][1] = ~m_par[2][1];
    do_read(4'd2);
    check("perr_pulse", {31'b0, parity_err}, 32'd1);
    check("perr_data", mem_rdata, 32'h0F0F0301);
    tick();
    check("perr_single", {31'b0, parity_err}, 32'd0);

    aresetn = 1'b0;
    tick();
    check("collision_cleared", {31'b0, wr_collision}, 32'd0);
    aresetn = 1'b1;
    for (int i = 0; i < 9; i++) tick();
    aresetn = 1'b0;
    tick(); tick();
    aresetn = 1'b1;
    mem_write = 1'b1; mem_read = 1'b1; mem_addr = 4'd5; mem_byteen = 4'hF; mem_wdata = 32'h55AA55AA;
    measure_busy(busy_cyc);
    check("refill_busy_cycles", busy_cyc, 32'd17);
    check("init_read_rdata", mem_rdata, 32'h0);
    check("init_read_nocol", {31'b0, wr_collision}, 32'd0);
    do_read(4'd0);
    check("refill_word0", mem_rdata, 32'h0);
    do_read(4'd3);
    check("refill_word3", mem_rdata, 32'h0);
    do_read(4'd15);
    check("refill_word15", mem_rdata, 32'h0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
